// File: rtl/seqdet_pkg.sv
// Shared definitions for the sequence-detector environment: the stimulus
// source state encoding and the default pattern geometry, which the detector
// benches reuse.
package seqdet_pkg;

   // Default number of bits per pattern word.
   localparam int SEQDET_WIDTH    = 8;
   // Default width of the repeat-count field.
   localparam int SEQDET_REPEAT_W = 4;

   // Serial source control states, 1-bit encoded.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } src_state_e;

endpackage : seqdet_pkg

// File: rtl/serial_bit_source.sv
// Serial bit source: accepts a pattern word through a valid/ready handshake
// and plays it out MSB-first on x_out, (load_repeat + 1) times back to back.
// The advance input holds the current bit when low. Every output except
// load_ready is registered; load_ready is decoded from the state register.
module serial_bit_source
   import seqdet_pkg::*;
#(
   parameter int WIDTH    = SEQDET_WIDTH,
   parameter int REPEAT_W = SEQDET_REPEAT_W
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [WIDTH-1:0]    load_data,
   input  logic [REPEAT_W-1:0] load_repeat,
   input  logic                advance,
   output logic                x_out,
   output logic                x_valid,
   output logic                busy,
   output logic                done
);

   // Bit counter wide enough to index every bit of a word.
   localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

   // State and datapath registers.
   src_state_e          r_state;
   logic [WIDTH-1:0]    r_shift;
   logic [WIDTH-1:0]    r_shadow;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic [REPEAT_W-1:0] r_rep_cnt;

   // Output registers.
   logic                r_x_out;
   logic                r_x_valid;
   logic                r_busy;
   logic                r_done;

   // Next-state values.
   src_state_e          w_state_nxt;
   logic [WIDTH-1:0]    w_shift_nxt;
   logic [WIDTH-1:0]    w_shadow_nxt;
   logic [CNT_W-1:0]    w_bit_cnt_nxt;
   logic [REPEAT_W-1:0] w_rep_cnt_nxt;
   logic                w_x_out_nxt;
   logic                w_x_valid_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;

   // Next-state and next-output decode; every register holds by default.
   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_shadow_nxt  = r_shadow;
      w_bit_cnt_nxt = r_bit_cnt;
      w_rep_cnt_nxt = r_rep_cnt;
      w_done_nxt    = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (load_valid) begin
               w_state_nxt   = ST_SHIFT;
               w_shift_nxt   = load_data;
               w_shadow_nxt  = load_data;
               w_bit_cnt_nxt = {CNT_W{1'b0}};
               w_rep_cnt_nxt = load_repeat;
            end else begin
               w_state_nxt   = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (!advance) begin
               // Stall: everything holds so x_out/x_valid stay stable.
               w_state_nxt = ST_SHIFT;
            end else if (r_bit_cnt != LAST_BIT) begin
               w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
            end else if (r_rep_cnt != {REPEAT_W{1'b0}}) begin
               // Reload with no bubble: next MSB follows immediately.
               w_shift_nxt   = r_shadow;
               w_bit_cnt_nxt = {CNT_W{1'b0}};
               w_rep_cnt_nxt = r_rep_cnt - REPEAT_W'(1);
            end else begin
               // Final bit consumed: return to IDLE and pulse done.
               w_state_nxt   = ST_IDLE;
               w_shift_nxt   = {WIDTH{1'b0}};
               w_bit_cnt_nxt = {CNT_W{1'b0}};
               w_done_nxt    = 1'b1;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_shift_nxt   = {WIDTH{1'b0}};
            w_bit_cnt_nxt = {CNT_W{1'b0}};
            w_rep_cnt_nxt = {REPEAT_W{1'b0}};
         end
      endcase

      // Outputs are computed from the next state so they can be registered
      // while still showing the first bit right after the accepting edge.
      w_x_valid_nxt = (w_state_nxt == ST_SHIFT);
      w_busy_nxt    = (w_state_nxt == ST_SHIFT);
      w_x_out_nxt   = w_x_valid_nxt & w_shift_nxt[WIDTH-1];
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_shift   <= {WIDTH{1'b0}};
         r_shadow  <= {WIDTH{1'b0}};
         r_bit_cnt <= {CNT_W{1'b0}};
         r_rep_cnt <= {REPEAT_W{1'b0}};
         r_x_out   <= 1'b0;
         r_x_valid <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_shadow  <= w_shadow_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_rep_cnt <= w_rep_cnt_nxt;
         r_x_out   <= w_x_out_nxt;
         r_x_valid <= w_x_valid_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign load_ready = (r_state == ST_IDLE);
   assign x_out      = r_x_out;
   assign x_valid    = r_x_valid;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule : serial_bit_source
